// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for the multiplexed 7-segment bus: decodes each scanned digit back to BCD and publishes 4-digit frames.
// Optional build macro SEG_BLANK_EN: seg FF decodes to digit F and ctl 1111 counts as blanking, not a select error.
module seg_scan_decoder #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] q_ctl_i,
   input  logic [7:0] q_out_i,
   output logic [3:0] dig0_o,
   output logic [3:0] dig1_o,
   output logic [3:0] dig2_o,
   output logic [3:0] dig3_o,
   output logic       frame_valid_o,
   output logic       pat_err_o,
   output logic       sel_err_o,
   output logic       link_lost_o
);

   localparam int SCW = $clog2(STABLE_CYCLES + 1);
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYCLES);
   localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT_CYCLES);

   logic [3:0]     ctl_s1_q, ctl_s2_q;
   logic [7:0]     seg_s1_q, seg_s2_q;
   logic [SCW-1:0] stab_q, stab_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic [3:0]     mask_q, mask_d;
   logic [3:0]     work_q [4];
   logic [3:0]     dig_q  [4];
   logic           fv_q, pat_q, pat_d, sel_q, sel_d, lost_q, lost_d;

   logic           sample_chg, ctl_chg, capture, timeout, frame;
   logic           sel_legal, sel_blank, wr_en;
   logic [1:0]     sel_idx;
   logic [4:0]     dec;

   // Returns {valid, value}; valid=0 marks an undecodable pattern.
   function automatic logic [4:0] seg_decode(input logic [7:0] seg);
      case (seg)
         8'h03:   seg_decode = {1'b1, 4'd0};
         8'h9F:   seg_decode = {1'b1, 4'd1};
         8'h25:   seg_decode = {1'b1, 4'd2};
         8'h0D:   seg_decode = {1'b1, 4'd3};
         8'h99:   seg_decode = {1'b1, 4'd4};
         8'h49:   seg_decode = {1'b1, 4'd5};
         8'h41:   seg_decode = {1'b1, 4'd6};
         8'h1B:   seg_decode = {1'b1, 4'd7};
         8'h01:   seg_decode = {1'b1, 4'd8};
         8'h09:   seg_decode = {1'b1, 4'd9};
`ifdef SEG_BLANK_EN
         8'hFF:   seg_decode = {1'b1, 4'hF};
`endif
         default: seg_decode = 5'd0;
      endcase
   endfunction

   always_comb begin
      sel_legal = 1'b1;
      sel_idx   = 2'd0;
      case (ctl_s2_q)
         4'b1110: sel_idx = 2'd0;
         4'b1101: sel_idx = 2'd1;
         4'b1011: sel_idx = 2'd2;
         4'b0111: sel_idx = 2'd3;
         default: sel_legal = 1'b0;
      endcase
   end

`ifdef SEG_BLANK_EN
   assign sel_blank = (ctl_s2_q == 4'hF);
`else
   assign sel_blank = 1'b0;
`endif

   // A change is detected as the synced value moves into the second stage.
   assign sample_chg = ({ctl_s1_q, seg_s1_q} != {ctl_s2_q, seg_s2_q});
   assign ctl_chg    = (ctl_s1_q != ctl_s2_q);
   assign capture    = !sample_chg && (stab_q == STAB_MAX - SCW'(1));
   assign timeout    = !ctl_chg && (wd_q == WD_MAX - WDW'(1));
   assign frame      = (mask_q == 4'hF);
   assign dec        = seg_decode(seg_s2_q);

   always_comb begin
      stab_d = stab_q;
      if (sample_chg)           stab_d = '0;
      else if (stab_q != STAB_MAX) stab_d = stab_q + SCW'(1);

      wd_d = wd_q;
      if (ctl_chg)              wd_d = '0;
      else if (wd_q != WD_MAX)  wd_d = wd_q + WDW'(1);

      mask_d = mask_q;
      pat_d  = 1'b0;
      sel_d  = 1'b0;
      wr_en  = 1'b0;
      if (frame) mask_d = '0;
      // Applied after the frame clear so a coincident capture keeps its bit.
      if (capture) begin
         if (sel_legal) begin
            if (dec[4]) begin
               wr_en           = 1'b1;
               mask_d[sel_idx] = 1'b1;
            end else begin
               pat_d = 1'b1;
            end
         end else if (!sel_blank) begin
            sel_d = 1'b1;
         end
      end
      if (timeout) mask_d = '0;

      lost_d = lost_q;
      if (ctl_chg)      lost_d = 1'b0;
      else if (timeout) lost_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_s1_q <= '0;
         ctl_s2_q <= '0;
         seg_s1_q <= '0;
         seg_s2_q <= '0;
         stab_q   <= '0;
         wd_q     <= '0;
         mask_q   <= '0;
         fv_q     <= 1'b0;
         pat_q    <= 1'b0;
         sel_q    <= 1'b0;
         lost_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            work_q[i] <= '0;
            dig_q[i]  <= '0;
         end
      end else begin
         ctl_s1_q <= q_ctl_i;
         ctl_s2_q <= ctl_s1_q;
         seg_s1_q <= q_out_i;
         seg_s2_q <= seg_s1_q;
         stab_q   <= stab_d;
         wd_q     <= wd_d;
         mask_q   <= mask_d;
         fv_q     <= frame;
         pat_q    <= pat_d;
         sel_q    <= sel_d;
         lost_q   <= lost_d;
         if (wr_en) work_q[sel_idx] <= dec[3:0];
         if (frame) begin
            for (int i = 0; i < 4; i++) dig_q[i] <= work_q[i];
         end
      end
   end

   assign dig0_o        = dig_q[0];
   assign dig1_o        = dig_q[1];
   assign dig2_o        = dig_q[2];
   assign dig3_o        = dig_q[3];
   assign frame_valid_o = fv_q;
   assign pat_err_o     = pat_q;
   assign sel_err_o     = sel_q;
   assign link_lost_o   = lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans digit patterns onto the bus and checks snapshots, pulses and timing.
module tb_seg_scan_decoder;

   localparam logic [3:0] D0 = 4'b1110;
   localparam logic [3:0] D1 = 4'b1101;
   localparam logic [3:0] D2 = 4'b1011;
   localparam logic [3:0] D3 = 4'b0111;
   localparam logic [7:0] SEG [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                       8'h49, 8'h41, 8'h1B, 8'h01, 8'h09};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] q_ctl_i;
   logic [7:0] q_out_i;
   logic [3:0] dig0_o, dig1_o, dig2_o, dig3_o;
   logic       frame_valid_o, pat_err_o, sel_err_o, link_lost_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int fv_cnt  = 0, pat_cnt = 0, sel_cnt = 0, fv_cyc = 0;
   int fv0, pat0, sel0, last_drive;

   seg_scan_decoder #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
      .clk(clk), .rst_n(rst_n), .q_ctl_i(q_ctl_i), .q_out_i(q_out_i),
      .dig0_o(dig0_o), .dig1_o(dig1_o), .dig2_o(dig2_o), .dig3_o(dig3_o),
      .frame_valid_o(frame_valid_o), .pat_err_o(pat_err_o),
      .sel_err_o(sel_err_o), .link_lost_o(link_lost_o)
   );

   // Clock and cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (frame_valid_o) begin
         fv_cnt = fv_cnt + 1;
         fv_cyc = cyc;
      end
      if (pat_err_o) pat_cnt = pat_cnt + 1;
      if (sel_err_o) sel_cnt = sel_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mark();
      fv0  = fv_cnt;
      pat0 = pat_cnt;
      sel0 = sel_cnt;
   endtask

   // Drives one dwell just after a rising edge, returns on a falling edge.
   task automatic show(input logic [3:0] ctl, input logic [7:0] seg, input int dwell);
      @(posedge clk);
      #1;
      q_ctl_i    = ctl;
      q_out_i    = seg;
      last_drive = cyc;
      repeat (dwell) @(negedge clk);
   endtask

   task automatic check_digs(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3);
      check({tag, "_dig0"}, dig0_o, e0);
      check({tag, "_dig1"}, dig1_o, e1);
      check({tag, "_dig2"}, dig2_o, e2);
      check({tag, "_dig3"}, dig3_o, e3);
   endtask

   initial begin
      rst_n   = 1'b0;
      q_ctl_i = D0;
      q_out_i = SEG[0];
      repeat (5) @(negedge clk);
      check_digs("rst", 4'd0, 4'd0, 4'd0, 4'd0);
      check("rst_fv", frame_valid_o, 0);
      check("rst_pat", pat_err_o, 0);
      check("rst_sel", sel_err_o, 0);
      check("rst_lost", link_lost_o, 0);
      rst_n = 1'b1;

      // Plain frame 3,3,1,2 and the capture-to-frame latency
      mark();
      show(D0, SEG[3], 200);
      show(D1, SEG[3], 200);
      show(D2, SEG[1], 200);
      show(D3, SEG[2], 200);
      check("t1_fv", fv_cnt - fv0, 1);
      check("t1_latency", fv_cyc - last_drive, 19);
      check_digs("t1", 4'd3, 4'd3, 4'd1, 4'd2);
      check("t1_pat", pat_cnt - pat0, 0);
      check("t1_sel", sel_cnt - sel0, 0);

      // Short d1 dwell is not captured
      mark();
      show(D0, SEG[4], 200);
      show(D1, SEG[5], 10);
      show(D2, SEG[6], 200);
      show(D3, SEG[7], 200);
      check("t2_fv_short", fv_cnt - fv0, 0);
      show(D1, SEG[5], 200);
      check("t2_fv", fv_cnt - fv0, 1);
      check("t2_latency", fv_cyc - last_drive, 19);
      check_digs("t2", 4'd4, 4'd5, 4'd6, 4'd7);

      // Bad pattern on d2
      mark();
      show(D0, SEG[8], 200);
      show(D1, SEG[9], 200);
      show(D2, 8'h55, 200);
      show(D3, SEG[0], 200);
      check("t3_pat", pat_cnt - pat0, 1);
      check("t3_fv_none", fv_cnt - fv0, 0);
      check_digs("t3_hold", 4'd4, 4'd5, 4'd6, 4'd7);
      show(D2, SEG[1], 200);
      check("t3_fv", fv_cnt - fv0, 1);
      check_digs("t3", 4'd8, 4'd9, 4'd1, 4'd0);

      // Illegal and blank selects, blank segments
      mark();
      show(4'b1100, SEG[0], 200);
      check("t4_sel_1100", sel_cnt - sel0, 1);
      show(4'b1111, 8'hFF, 200);
`ifdef SEG_BLANK_EN
      check("t4_sel_1111", sel_cnt - sel0, 1);
`else
      check("t4_sel_1111", sel_cnt - sel0, 2);
`endif
      check("t4_fv_none", fv_cnt - fv0, 0);
      check("t4_pat_none", pat_cnt - pat0, 0);
      show(D0, 8'hFF, 200);
      show(D1, SEG[2], 200);
      show(D2, SEG[3], 200);
      show(D3, SEG[4], 200);
      show(D0, SEG[5], 200);
      check("t4_fv", fv_cnt - fv0, 1);
`ifdef SEG_BLANK_EN
      check("t4_pat_ff", pat_cnt - pat0, 0);
      check_digs("t4", 4'hF, 4'd2, 4'd3, 4'd4);
`else
      check("t4_pat_ff", pat_cnt - pat0, 1);
      check_digs("t4", 4'd5, 4'd2, 4'd3, 4'd4);
`endif

      // Frozen select trips the watchdog and drops the partial frame
      mark();
      show(D0, SEG[6], 200);
      show(D1, SEG[2], 990);
      check("t5_lost_early", link_lost_o, 0);
      show(D1, SEG[2], 110);
      check("t5_lost", link_lost_o, 1);
      check("t5_dig1_hold", dig1_o, 4'd2);
      show(D2, SEG[7], 200);
      check("t5_lost_clear", link_lost_o, 0);
      show(D3, SEG[8], 200);
      check("t5_fv_none", fv_cnt - fv0, 0);
      show(D0, SEG[9], 200);
      show(D1, SEG[1], 200);
      check("t5_fv", fv_cnt - fv0, 1);
      check_digs("t5", 4'd9, 4'd1, 4'd7, 4'd8);

      // Asynchronous reset mid-frame
      show(D2, SEG[2], 200);
      show(D3, SEG[3], 100);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_digs("t6_rst", 4'd0, 4'd0, 4'd0, 4'd0);
      check("t6_rst_fv", frame_valid_o, 0);
      check("t6_rst_lost", link_lost_o, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mark();
      show(D0, SEG[1], 200);
      show(D1, SEG[2], 200);
      show(D3, SEG[4], 200);
      check("t6_fv_none", fv_cnt - fv0, 0);
      show(D2, SEG[5], 200);
      check("t6_fv", fv_cnt - fv0, 1);
      check_digs("t6", 4'd1, 4'd2, 4'd5, 4'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
